// File: rtl/pipelined_cla_addsub_if.sv
// rtl/pipelined_cla_addsub_if.sv - request/result bundle for the sliced CLA add/sub unit

interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic [WIDTH-1:0] R;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             busy;
    logic             done;

    // requester side: issues operations, observes results and status
    modport master (
        output start, op, A, B, cin,
        input  R, cout, ovf, zero, busy, done
    );

    // arithmetic unit side
    modport slave (
        input  start, op, A, B, cin,
        output R, cout, ovf, zero, busy, done
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - multi-cycle add/sub, one carry-lookahead slice per clock

module pipelined_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    pipelined_cla_addsub_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    generate
        if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("pipelined_cla_addsub: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;     // already inverted for subtract ops
    logic [WIDTH-1:0] part;      // slices completed so far
    logic             carry;     // carry into the current slice

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] gen;
    logic [SLICE-1:0] prop;
    logic [SLICE-1:0] s_sl;
    logic [SLICE:0]   c;
    logic [WIDTH-1:0] next_part;
    int               base;

    // Current slice: every carry is a flat generate/propagate sum of products
    // rooted at the registered carry, so no ripple exists inside a slice.
    always_comb begin
        logic acc;
        logic pchain;
        acc       = 1'b0;
        pchain    = 1'b0;
        base      = int'(cnt) * SLICE;
        a_sl      = a_reg[base +: SLICE];
        b_sl      = b_reg[base +: SLICE];
        gen       = a_sl & b_sl;
        prop      = a_sl ^ b_sl;
        c         = '0;
        c[0]      = carry;
        for (int j = 0; j < SLICE; j++) begin
            acc    = gen[j];
            pchain = prop[j];
            for (int k = j - 1; k >= 0; k--) begin
                acc    = acc | (pchain & gen[k]);
                pchain = pchain & prop[k];
            end
            c[j+1] = acc | (pchain & carry);
        end
        s_sl      = prop ^ c[SLICE-1:0];
        next_part = part;
        next_part[base +: SLICE] = s_sl;
    end

    // Control and datapath: capture on start, one slice per edge, publish on the last
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            part     <= '0;
            carry    <= 1'b0;
            bus.R    <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.zero <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg    <= bus.A;
                        b_reg    <= bus.op[1] ? ~bus.B : bus.B;
                        // ADD:0, ADC:cin, SUB:1, SBC:cin
                        carry    <= bus.op[0] ? bus.cin : bus.op[1];
                        cnt      <= '0;
                        part     <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    part  <= next_part;
                    carry <= c[SLICE];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        bus.R    <= next_part;
                        bus.cout <= c[SLICE];
                        bus.ovf  <= c[SLICE] ^ c[SLICE-1];
                        bus.zero <= (next_part == '0);
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - scoreboard bench for pipelined_cla_addsub

module tb_pipelined_cla_addsub;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    longint cyc = 0;
    int     checks = 0;
    int     failures = 0;
    bit     mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_cla_addsub_if #(.WIDTH(32)) bus0 ();
    pipelined_cla_addsub_if #(.WIDTH(8))  bus1 ();
    pipelined_cla_addsub_if #(.WIDTH(16)) bus2 ();

    pipelined_cla_addsub #(.WIDTH(32), .SLICE(8)) u0 (.clk(clk), .reset(reset), .bus(bus0));
    pipelined_cla_addsub #(.WIDTH(8),  .SLICE(8)) u1 (.clk(clk), .reset(reset), .bus(bus1));
    pipelined_cla_addsub #(.WIDTH(16), .SLICE(4)) u2 (.clk(clk), .reset(reset), .bus(bus2));

    typedef struct {
        logic [31:0] r;
        logic        cout;
        logic        ovf;
        logic        zero;
        longint      due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    function automatic int width_of(int d);
        return (d == 0) ? 32 : (d == 1) ? 8 : 16;
    endfunction

    function automatic int cycles_of(int d);
        return (d == 1) ? 1 : 4;
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    endfunction

    function automatic exp_t qfront(int d);
        return (d == 0) ? q0[0] : (d == 1) ? q1[0] : q2[0];
    endfunction

    function automatic longint qlast_due(int d);
        return (d == 0) ? q0[$].due : (d == 1) ? q1[$].due : q2[$].due;
    endfunction

    task automatic qpush(int d, exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(int d);
        exp_t e;
        case (d)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic qclear(int d);
        case (d)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        failures++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // Reference: plain modulo arithmetic, overflow from operand/result signs.
    function automatic exp_t model(int w, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic c);
        logic [63:0] mask, aa, bb, sum;
        logic        ci;
        exp_t        e;
        mask   = (64'd1 << w) - 64'd1;
        aa     = {32'd0, a} & mask;
        bb     = op[1] ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
        ci     = op[0] ? c : op[1];
        sum    = aa + bb + {63'd0, ci};
        e.r    = 32'(sum & mask);
        e.cout = sum[w];
        e.zero = ((sum & mask) == 64'd0);
        e.ovf  = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
        e.due  = 0;
        return e;
    endfunction

    task automatic set_inputs(int d, logic s, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic c);
        case (d)
            0: begin bus0.start = s; bus0.op = op; bus0.A = a;       bus0.B = b;       bus0.cin = c; end
            1: begin bus1.start = s; bus1.op = op; bus1.A = a[7:0];  bus1.B = b[7:0];  bus1.cin = c; end
            default: begin bus2.start = s; bus2.op = op; bus2.A = a[15:0]; bus2.B = b[15:0]; bus2.cin = c; end
        endcase
    endtask

    // Present a request for one edge; the model decides whether it is accepted.
    task automatic drive(int d, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic c);
        exp_t e;
        bit   acc;
        set_inputs(d, 1'b1, op, a, b, c);
        @(posedge clk);
        #1;
        acc = (qsize(d) == 0) || (cyc > qlast_due(d));
        if (acc) begin
            e     = model(width_of(d), op, a, b, c);
            e.due = cyc + cycles_of(d);
            qpush(d, e);
        end
        set_inputs(d, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic wait_idle(int d);
        int n = 0;
        while (qsize(d) != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (qsize(d) != 0) begin
            fail_now($sformatf("timeout_dut%0d", d));
            qclear(d);
        end
    endtask

    task automatic mon(int d, logic busy, logic done, logic [31:0] r, logic co, logic ov, logic ze);
        exp_t e;
        bit   pend;
        pend = (qsize(d) != 0);
        if (pend) e = qfront(d);
        else e = '{r: 32'h0, cout: 1'b0, ovf: 1'b0, zero: 1'b0, due: 0};
        chk($sformatf("busy%0d", d), 32'(busy), 32'(pend && (cyc < e.due)));
        if (done) begin
            if (!pend) begin
                fail_now($sformatf("spurious_done%0d", d));
            end else begin
                qpop(d);
                chk($sformatf("R%0d", d),    r,          e.r);
                chk($sformatf("cout%0d", d), 32'(co),    32'(e.cout));
                chk($sformatf("ovf%0d", d),  32'(ov),    32'(e.ovf));
                chk($sformatf("zero%0d", d), 32'(ze),    32'(e.zero));
                chk($sformatf("lat%0d", d),  32'(cyc),   32'(e.due));
            end
        end else if (pend && cyc >= e.due) begin
            fail_now($sformatf("missing_done%0d", d));
            qpop(d);
        end
    endtask

    // Monitors sample on the falling edge, independent of the stimulus process
    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, bus0.busy, bus0.done, bus0.R,        bus0.cout, bus0.ovf, bus0.zero);
            mon(1, bus1.busy, bus1.done, 32'(bus1.R),   bus1.cout, bus1.ovf, bus1.zero);
            mon(2, bus2.busy, bus2.done, 32'(bus2.R),   bus2.cout, bus2.ovf, bus2.zero);
        end
    end

    function automatic logic [31:0] pick(int w);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h1 << (w - 1);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        set_inputs(0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        set_inputs(1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        set_inputs(2, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_R",    bus0.R,           32'h0);
        chk("reset_busy", 32'(bus0.busy),   32'h0);
        chk("reset_done", 32'(bus0.done),   32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        drive(0, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0); wait_idle(0);
        drive(0, OP_ADC, 32'h0000_00FF, 32'h0000_0000, 1'b1); wait_idle(0);
        drive(0, OP_ADD, 32'h0000_00FF, 32'h0000_0000, 1'b1); wait_idle(0);
        drive(0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0); wait_idle(0);
        drive(0, OP_SUB, 32'h0000_0005, 32'h0000_0007, 1'b0); wait_idle(0);
        drive(0, OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0); wait_idle(0);

        // restarts during an operation are ignored
        drive(0, OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b0);
        for (int i = 0; i < 3; i++)
            drive(0, 2'($urandom), $urandom, $urandom, 1'($urandom));
        wait_idle(0);

        // a new start presented during the done cycle is accepted
        drive(0, OP_SBC, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        drive(0, OP_ADC, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
        wait_idle(0);

        drive(1, OP_SBC, 32'h10, 32'h01, 1'b0);     wait_idle(1);
        drive(2, OP_ADD, 32'h0FFF, 32'h0001, 1'b0); wait_idle(2);

        for (int i = 0; i < 45; i++) begin
            int d;
            d = i % 3;
            drive(d, 2'($urandom), pick(width_of(d)), pick(width_of(d)), 1'($urandom));
            if ($urandom_range(0, 2) == 0)
                drive(d, 2'($urandom), $urandom, $urandom, 1'($urandom));
            wait_idle(d);
        end

        // asynchronous reset in the middle of an operation
        drive(0, OP_ADD, 32'h0101_0101, 32'h0202_0202, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_R",    bus0.R,          32'h0);
        chk("midrst_cout", 32'(bus0.cout),  32'h0);
        chk("midrst_ovf",  32'(bus0.ovf),   32'h0);
        chk("midrst_zero", 32'(bus0.zero),  32'h0);
        chk("midrst_busy", 32'(bus0.busy),  32'h0);
        chk("midrst_done", 32'(bus0.done),  32'h0);
        qclear(0);
        #1;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        drive(0, OP_SUB, 32'h0000_0100, 32'h0000_0001, 1'b0);
        wait_idle(0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
